up_operand_driver: RTL and testbench

UP_OPERAND_DRIVER -- requirements
Module: up_operand_driver

---
 rtl/up_drv_pkg.sv | 35 +++
 rtl/up_drv_cnt.sv | 31 +++
 rtl/up_operand_driver.sv | 150 +++++++++++++++
 tb/tb_up_operand_driver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_drv_pkg.sv
// Shared types and default timing for the up_operand_driver block.
package up_drv_pkg;

  typedef logic [7:0] data_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP_A,
    ENTER_A,
    GAP,
    SETUP_B,
    ENTER_B,
    WAIT_HALT,
    DONE
  } state_e;

  localparam int unsigned DEF_SETUP_CYC   = 5;
  localparam int unsigned DEF_ENTER_CYC   = 2;
  localparam int unsigned DEF_GAP_CYC     = 15;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

  // Number of cycles a state occupies; 0 for states not timed by the counter.
  function automatic data_t phase_len(input state_e s, input data_t setup,
                                      input data_t enter, input data_t gap,
                                      input data_t tmo);
    case (s)
      SETUP_A, SETUP_B: return setup;
      ENTER_A, ENTER_B: return enter;
      GAP:              return gap;
      WAIT_HALT:        return tmo;
      default:          return '0;
    endcase
  endfunction

endpackage

// File: rtl/up_drv_cnt.sv
// Loadable 8-bit down-counter; saturates at 0, terminal flag at 1.
module up_drv_cnt
  import up_drv_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  data_t load_val,
  output logic  term
);

  data_t cnt_d, cnt_q;

  // Load has priority; otherwise count down without wrapping below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign term = (cnt_q == 8'd1);

endmodule

// File: rtl/up_operand_driver.sv
// Drives two operands to a simple processor (Input/Enter handshake), then
// waits for a Halt rising edge and captures the processor's Output.
// Optional feature macro: UP_DRV_TIMEOUT_EN enables the WAIT_HALT abort.
module up_operand_driver
  import up_drv_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
  parameter int unsigned ENTER_CYC   = DEF_ENTER_CYC,
  parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic  CLOCK,
  input  logic  RESET,
  input  logic  Start,
  input  data_t OpA,
  input  data_t OpB,
  output logic  Busy,
  output logic  Init,
  output data_t Input,
  output logic  Enter,
  input  logic  Halt,
  input  data_t Output,
  output data_t Result,
  output logic  ResultValid,
  output logic  Timeout
);

  state_e state_d, state_q;
  data_t  opa_d, opa_q, opb_d, opb_q;
  data_t  result_d, result_q;
  logic   rvalid_d, rvalid_q;
  logic   enter_d, enter_q;
  logic   halt_d, halt_q;
  logic   init_d, init_q;
  logic   rst_dly_d, rst_dly_q;
  logic   cnt_load, cnt_term;
  data_t  cnt_val;
`ifdef UP_DRV_TIMEOUT_EN
  logic   timeout_d, timeout_q;
`endif

  // All phase timing shares one counter, reloaded on every state change.
  up_drv_cnt u_cnt (
    .clk      (CLOCK),
    .rst      (RESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .term     (cnt_term)
  );

  // Next-state and datapath updates for the operand sequencer.
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    rvalid_d  = 1'b0;
    halt_d    = Halt;
    rst_dly_d = 1'b0;
    init_d    = rst_dly_q;
`ifdef UP_DRV_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE:
        if (Start && !init_q) begin
          opa_d   = OpA;
          opb_d   = OpB;
          state_d = SETUP_A;
        end
      SETUP_A: if (cnt_term) state_d = ENTER_A;
      ENTER_A: if (cnt_term) state_d = GAP;
      GAP:     if (cnt_term) state_d = SETUP_B;
      SETUP_B: if (cnt_term) state_d = ENTER_B;
      ENTER_B: if (cnt_term) state_d = WAIT_HALT;
      WAIT_HALT:
        // Only a fresh rising edge of Halt counts as completion.
        if (Halt && !halt_q) begin
          result_d = Output;
          rvalid_d = 1'b1;
          state_d  = DONE;
        end
`ifdef UP_DRV_TIMEOUT_EN
        else if (cnt_term) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_load = (state_d != state_q);
    cnt_val  = phase_len(state_d, data_t'(SETUP_CYC), data_t'(ENTER_CYC),
                         data_t'(GAP_CYC), data_t'(TIMEOUT_CYC));
    enter_d  = (state_d == ENTER_A) || (state_d == ENTER_B);
  end

  // State and output registers; Init stretches one cycle past reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      rvalid_q  <= 1'b0;
      enter_q   <= 1'b0;
      halt_q    <= 1'b0;
      init_q    <= 1'b1;
      rst_dly_q <= 1'b1;
`ifdef UP_DRV_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      rvalid_q  <= rvalid_d;
      enter_q   <= enter_d;
      halt_q    <= halt_d;
      init_q    <= init_d;
      rst_dly_q <= rst_dly_d;
`ifdef UP_DRV_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  // Operand bus follows the phase: A up to the gap, B afterwards, 0 when idle.
  always_comb begin
    Input = '0;
    case (state_q)
      SETUP_A, ENTER_A, GAP:              Input = opa_q;
      SETUP_B, ENTER_B, WAIT_HALT, DONE:  Input = opb_q;
      default:                            Input = '0;
    endcase
  end

  assign Busy        = (state_q != IDLE);
  assign Init        = init_q;
  assign Enter       = enter_q;
  assign Result      = result_q;
  assign ResultValid = rvalid_q;
`ifdef UP_DRV_TIMEOUT_EN
  assign Timeout     = timeout_q;
`else
  assign Timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_up_operand_driver.sv
// Scoreboard bench for up_operand_driver with a behavioural processor model.
module tb_up_operand_driver;
  import up_drv_pkg::*;

`ifdef UP_DRV_TIMEOUT_EN
  localparam int TMO = 10;
  localparam int DIR_DLY = 8;
`else
  localparam int TMO = 255;
  localparam int DIR_DLY = 40;
`endif
  localparam int SU = DEF_SETUP_CYC;
  localparam int EN = DEF_ENTER_CYC;
  localparam int GP = DEF_GAP_CYC;

  typedef struct { bit is_to; logic [7:0] val; } exp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, halt = 1'b0;
  logic [7:0] opa = '0, opb = '0, outp = '0;
  logic busy, init, enter, rvalid, tmo_o;
  logic [7:0] inp, result;

  int cyc = 0, checks = 0, errors = 0;
  int mode = 0, hdly = 2, wait_entry = 0;
  bit hold_mode = 1'b0;
  logic [7:0] hold_exp = '0, last_res = '0;
  exp_t sb[$];

  up_operand_driver #(.TIMEOUT_CYC(TMO)) dut (
    .CLOCK(clk), .RESET(rst), .Start(start), .OpA(opa), .OpB(opb),
    .Busy(busy), .Init(init), .Input(inp), .Enter(enter), .Halt(halt),
    .Output(outp), .Result(result), .ResultValid(rvalid), .Timeout(tmo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Processor model: latches both operands on Enter rises and answers a-b-1.
  initial begin : proc
    int n, r2, k;
    logic [7:0] a, b;
    logic ep;
    n = 0; r2 = 0; k = 0; a = '0; b = '0; ep = 1'b0;
    forever begin
      @(negedge clk);
      if (init) begin
        n = 0; halt = 1'b0; ep = 1'b0;
      end else begin
        if (enter && !ep) begin
          n++;
          if (n == 1) begin
            a = inp;
            if (mode == 2) begin halt = 1'b1; outp = 8'h11; end
          end else if (n == 2) begin
            b = inp; r2 = cyc; wait_entry = cyc + EN;
          end
        end
        ep = enter;
        if (n == 2) begin
          k = cyc - r2;
          case (mode)
            0: if (k == hdly) begin halt = 1'b1; outp = a - b - 8'd1; end
               else if (k == hdly + 1) begin halt = 1'b0; n = 0; end
            2: if (k == EN + 4) halt = 1'b0;
               else if (k == EN + 5) begin halt = 1'b1; outp = 8'hA5; end
               else if (k == EN + 6) begin halt = 1'b0; n = 0; end
            default: if (k == EN) n = 0;
          endcase
        end
      end
    end
  end

  // Monitor: Enter timing per transaction and scoreboard pops on results.
  initial begin : mon
    int rises, run, r1, tacc;
    logic bp, ep;
    exp_t e;
    rises = 0; run = 0; r1 = 0; tacc = 0; bp = 1'b0; ep = 1'b0;
    forever begin
      @(negedge clk);
      if (init) begin
        rises = 0; run = 0; bp = 1'b0; ep = 1'b0;
      end else begin
        if (busy && !bp) begin
          tacc = cyc; rises = 0;
          if (hold_mode) sb.push_back('{1'b0, hold_exp});
        end
        if (!busy && bp) chk("enter_count", rises, 2);
        if (!busy) chk("input_idle", inp, 0);
        if (enter) begin
          if (!ep) begin
            rises++;
            if (rises == 1) begin r1 = cyc; chk("enter1_delay", cyc - tacc, SU); end
            else chk("enter_spacing", cyc - r1, EN + GP + SU);
          end
          run++;
        end else if (ep) begin
          chk("enter_width", run, EN);
          run = 0;
        end
        if (rvalid) begin
          chk("rvalid_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rvalid_kind", e.is_to, 0);
            chk("result", result, e.val);
            last_res = e.val;
          end
        end
        if (tmo_o) begin
          chk("timeout_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("timeout_kind", e.is_to, 1);
            chk("timeout_cycle", cyc - wait_entry, TMO);
            chk("timeout_result", result, last_res);
            chk("timeout_busy", busy, 0);
          end
        end
        bp = busy; ep = enter;
      end
    end
  end

  task automatic wait_idle(input int lim);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < lim) begin @(negedge clk); i++; end
    chk("idle_reached", busy, 0);
  endtask

  // Issue one accepted Start from IDLE and record the expected response.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input int m, input int d);
    logic [7:0] ev;
    wait_idle(300);
    opa = a; opb = b; mode = m; hdly = d; start = 1'b1;
    ev = a - b - 8'd1;
    if (m == 1)      sb.push_back('{1'b1, 8'h00});
    else if (m == 2) sb.push_back('{1'b0, 8'hA5});
    else             sb.push_back('{1'b0, ev});
    @(negedge clk);
    start = 1'b0; opa = 8'($urandom); opb = 8'($urandom);
    chk("accept_busy", busy, 1);
  endtask

  // Let a transaction run, sprinkling Starts that must be ignored.
  task automatic run_busy(input int lim);
    int i;
    i = 0;
    while (busy === 1'b1 && i < lim) begin
      start = ($urandom_range(0, 7) == 0);
      opa = 8'($urandom); opb = 8'($urandom);
      @(negedge clk); i++;
    end
    start = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    logic bprev;
    int i;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_enter", enter, 0);
    chk("rst_input", inp, 0);
    chk("rst_result", result, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_timeout", tmo_o, 0);
    chk("rst_init", init, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("init_hold", init, 1);
    start = 1'b1; opa = 8'h77; opb = 8'h22;
    @(negedge clk);
    chk("init_fall", init, 0);
    chk("start_ignored_init", busy, 0);
    start = 1'b0;

    // Directed: OpA=3, OpB=1, processor answers 1.
    issue(8'd3, 8'd1, 0, DIR_DLY);
    run_busy(400);

    // Randomized transactions.
    for (int t = 0; t < 15; t++) begin
      issue(8'($urandom), 8'($urandom), 0, $urandom_range(EN, EN + 7));
      run_busy(400);
    end

    // Halt already high on WAIT_HALT entry must not complete.
    issue(8'h40, 8'h10, 2, 0);
    run_busy(400);

`ifdef UP_DRV_TIMEOUT_EN
    issue(8'h55, 8'h05, 1, 0);
    run_busy(400);
    @(negedge clk);
    chk("busy_after_timeout", busy, 0);
    issue(8'h20, 8'h02, 0, EN + 1);
    run_busy(400);
`endif

    // Start held for 100 cycles: one transaction per IDLE visit.
    wait_idle(300);
    mode = 0; hdly = EN + 1; opa = 8'd9; opb = 8'd4; hold_exp = 8'd4;
    hold_mode = 1'b1; start = 1'b1;
    bprev = 1'b0;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b0) chk("hold_idle_single", bprev, 1);
      bprev = busy;
    end
    start = 1'b0;
    run_busy(400);
    wait_idle(300);
    hold_mode = 1'b0;

    // Reset during ENTER_A aborts the transaction.
    issue(8'hC3, 8'h3C, 0, EN + 2);
    i = 0;
    while (enter !== 1'b1 && i < 50) begin @(negedge clk); i++; end
    chk("reach_enter_a", enter, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    last_res = '0;
    chk("mid_rst_enter", enter, 0);
    chk("mid_rst_input", inp, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_init", init, 1);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_result", result, 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_init_fall", init, 0);

    issue(8'hF0, 8'h0F, 0, EN + 3);
    run_busy(400);
    wait_idle(300);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
